// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sums N_PP aligned radix-4 Booth partial products per
// product and hands the result out over a valid/ready handshake.
// Optional: define BOOTH_ACC_OVF_EN to build sticky signed-overflow detection.
module booth_pp_accumulator #(
  parameter int unsigned W    = 8,
  parameter int unsigned N_PP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         pp_valid,
  output logic         pp_ready,
  input  logic [W-1:0] pp_data,
  output logic         p_valid,
  input  logic         p_ready,
  output logic [W-1:0] p_data,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N_PP) + 1;

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_c;
  logic          beat_c;

  // Handshake and status outputs derive from registered state; only the
  // clear override on pp_ready is combinational.
  assign pp_ready = (state_q == ST_ACC) && !clear;
  assign p_valid  = (state_q == ST_OUT);
  assign p_data   = acc_q;
  assign busy     = (state_q == ST_OUT) || (cnt_q != '0);
  assign beat_c   = pp_valid && pp_ready;
  assign sum_c    = acc_q + pp_data;

`ifdef BOOTH_ACC_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_add_c;

  // Signed overflow of one add: equal operand signs, different result sign.
  assign ovf_add_c = (acc_q[W-1] == pp_data[W-1]) && (sum_c[W-1] != acc_q[W-1]);
  assign ovf       = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Next-state logic: clear dominates, then accumulate or hand out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`ifdef BOOTH_ACC_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (clear) begin
      state_d = ST_ACC;
      cnt_d   = '0;
      acc_d   = '0;
`ifdef BOOTH_ACC_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (beat_c) begin
            if (cnt_q == '0) begin
              acc_d = pp_data;
`ifdef BOOTH_ACC_OVF_EN
              ovf_d = 1'b0;
`endif
            end else begin
              acc_d = sum_c;
`ifdef BOOTH_ACC_OVF_EN
              ovf_d = ovf_q | ovf_add_c;
`endif
            end
            if (cnt_q == CW'(N_PP - 1)) begin
              state_d = ST_OUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_OUT: begin
          if (p_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

`ifdef BOOTH_ACC_OVF_EN
  // Sticky overflow flag for the product being built or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Testbench for booth_pp_accumulator (W=8, N_PP=2): directed scenarios plus
// randomized products checked against an integer-arithmetic reference model.
module tb_booth_pp_accumulator;

  localparam int unsigned W    = 8;
  localparam int unsigned N_PP = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         pp_valid;
  logic         pp_ready;
  logic [W-1:0] pp_data;
  logic         p_valid;
  logic         p_ready;
  logic [W-1:0] p_data;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];

  booth_pp_accumulator #(.W(W), .N_PP(N_PP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp_data  (pp_data),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_data   (p_data),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact integer sum of the beats, wrapped to W bits; overflow is
  // any running sum (after the first beat) leaving the signed W-bit range.
  function automatic logic [8:0] ref_prod(input logic [7:0] b0, input logic [7:0] b1);
    int cur;
    int exact;
    logic o;
    logic [7:0] w;
    cur   = int'($signed(b0));
    exact = cur + int'($signed(b1));
    o     = (exact > 127) || (exact < -128);
    w     = 8'(exact);
`ifdef BOOTH_ACC_OVF_EN
    return {o, w};
`else
    return {1'b0 & o, w};
`endif
  endfunction

  // Present one beat and hold it until accepted.
  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    pp_valid = 1'b1;
    pp_data  = d;
    #1;
    while (!pp_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'(pp_ready), 32'd1);
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
  endtask

  // Check the product one cycle after the last beat, then accept it.
  task automatic expect_product(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    logic [8:0] e;
    e = ref_prod(b0, b1);
    @(negedge clk);
    check({tag, "_pvalid"}, 32'(p_valid), 32'd1);
    check({tag, "_pdata"}, 32'(p_data), 32'(e[7:0]));
    check({tag, "_ovf"}, 32'(ovf), 32'(e[8]));
  endtask

  task automatic accept_product();
    p_ready = 1'b1;
    @(posedge clk);
    #1;
    p_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    rst_n    = 1'b0;
    clear    = 1'b0;
    pp_valid = 1'b0;
    pp_data  = '0;
    p_ready  = 1'b0;
    #12;
    check("rst_pp_ready", 32'(pp_ready), 32'd1);
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product 5*3
    send_beat(8'hFB);
    send_beat(8'h14);
    expect_product("basic", 8'hFB, 8'h14);
    accept_product();
    @(negedge clk);
    check("basic_ret_pp_ready", 32'(pp_ready), 32'd1);
    check("basic_ret_p_valid", 32'(p_valid), 32'd0);

    // Negative product held under backpressure
    send_beat(8'hFA);
    send_beat(8'h00);
    expect_product("neg", 8'hFA, 8'h00);
    pp_valid = 1'b1;
    pp_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("neg_hold_pdata", 32'(p_data), 32'hFA);
      check("neg_hold_pp_ready", 32'(pp_ready), 32'd0);
      check("neg_hold_pvalid", 32'(p_valid), 32'd1);
    end
    pp_valid = 1'b0;
    accept_product();
    @(negedge clk);
    check("neg_busy_after", 32'(busy), 32'd0);

    // Overflow, then a clean product
    send_beat(8'h70);
    send_beat(8'h70);
    expect_product("ovf", 8'h70, 8'h70);
    accept_product();
    send_beat(8'h01);
    send_beat(8'h01);
    expect_product("post_ovf", 8'h01, 8'h01);
    accept_product();

    // Clear mid-product
    send_beat(8'h10);
    @(negedge clk);
    check("clr_busy_mid", 32'(busy), 32'd1);
    clear    = 1'b1;
    pp_valid = 1'b1;
    pp_data  = 8'h20;
    #1;
    check("clr_pp_ready", 32'(pp_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    pp_valid = 1'b0;
    @(negedge clk);
    check("clr_busy_next", 32'(busy), 32'd0);
    send_beat(8'h03);
    send_beat(8'h04);
    expect_product("after_clr", 8'h03, 8'h04);
    accept_product();

    // Async reset while holding a product
    send_beat(8'h11);
    send_beat(8'h22);
    expect_product("pre_rst", 8'h11, 8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_p_valid", 32'(p_valid), 32'd0);
    check("arst_pp_ready", 32'(pp_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;
    send_beat(8'h01);
    send_beat(8'h02);
    expect_product("after_rst", 8'h01, 8'h02);
    accept_product();

    // Random products with gappy pp_valid and p_ready tied high
    p_ready = 1'b1;
    pulses  = 0;
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          logic [7:0] b[2];
          b[0] = 8'($urandom);
          b[1] = 8'($urandom);
          exp_q.push_back(ref_prod(b[0], b[1]));
          for (int k = 0; k < 2; k++) begin
            bit acc_done;
            int guard;
            acc_done = 1'b0;
            guard    = 0;
            while (!acc_done && guard < 100) begin
              @(negedge clk);
              pp_data  = b[k];
              pp_valid = 1'($urandom_range(0, 1));
              #1;
              if (pp_valid && pp_ready) acc_done = 1'b1;
              guard++;
            end
            if (!acc_done) check("rand_beat_timeout", 32'd0, 32'd1);
          end
        end
        @(negedge clk);
        pp_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 600; c++) begin
          @(negedge clk);
          if (p_valid) begin
            logic [8:0] e;
            pulses++;
            if (exp_q.size() == 0) begin
              check("rand_unexpected", 32'(p_data), 32'hFFFF);
            end else begin
              e = exp_q.pop_front();
              check("rand_pdata", 32'(p_data), 32'(e[7:0]));
              check("rand_ovf", 32'(ovf), 32'(e[8]));
            end
          end
        end
      end
    join
    check("rand_pulses", 32'(pulses), 32'd4);
    p_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Consumer end of the radix-4 Booth partial-product interface: accepts pre-aligned, sign-extended partial products one per handshake and sums them into a signed product.
- Sits between the Booth encoder/PP generator and downstream logic, so PP generation and accumulation are time-multiplexed instead of fully combinational.
- Emits one product per N_PP accepted partial products over a valid/ready output handshake.

Parameters:
- W, 8, width of partial products, accumulator and product (two's complement).
- N_PP, 2, partial products per product; must be >= 1 (radix-4: (operand_width+1)/2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the partial sum and any pending product.
- pp_valid  input  1  partial product present on pp_data.
- pp_ready  output  1  block accepts a partial product this cycle.
- pp_data  input  W  signed partial product, already aligned (shifted by 2*i) and sign-extended.
- p_valid  output  1  product available on p_data.
- p_ready  input  1  downstream accepts the product.
- p_data  output  W  signed product; valid only while p_valid=1.
- ovf  output  1  signed-overflow flag for the current product, qualified by p_valid (see Optional Feature).
- busy  output  1  high when a product is partially accumulated or waiting in OUT.

Behaviour:
- Reset (rst_n=0, async): state=ACC, cnt=0, acc=0, ovf=0; outputs pp_ready=1, p_valid=0, p_data=0, ovf=0, busy=0. A reset mid-product discards it.
- State ACC:
  - pp_ready = !clear; p_valid=0.
  - Beat accepted when pp_valid && pp_ready.
  - On a beat: acc <= (cnt==0) ? pp_data : acc + pp_data, truncated to W bits (modulo 2^W); cnt <= cnt+1.
  - When the accepted beat is beat number N_PP (cnt==N_PP-1), go to OUT and set cnt <= 0.
- State OUT:
  - pp_ready=0; p_valid=1; p_data=acc.
  - On p_ready=1, return to ACC.
  - p_data and ovf stay stable while p_valid=1 && p_ready=0.
- Latency: p_valid rises the cycle after the last beat is accepted.
- Throughput: minimum N_PP+1 cycles per product. There is no bypass: a beat is not accepted in the same cycle p_valid drops.
- clear=1 has priority over everything:
  - Next state ACC; cnt=0; acc=0; ovf=0.
  - Any beat presented that cycle is not accepted, because pp_ready is forced low.
  - A product held in OUT is dropped without a p_ready handshake.
- busy = (state==OUT) || (cnt != 0).
- N_PP=1: every accepted beat goes straight to OUT with acc=pp_data.
- pp_valid may assert or deassert freely between beats; gaps do not affect the result.
- Counter width: clog2(N_PP)+1 bits.

Optional Feature:
- Macro: BOOTH_ACC_OVF_EN.
- When defined:
  - On each add, detect signed overflow: operand sign bits equal and result sign differs.
  - ovf is sticky across the beats of one product.
  - ovf is cleared when the first beat of the next product is accepted, and on clear or reset.
  - The first beat never sets ovf.
- When undefined: ovf is tied to 0 and no overflow logic is synthesised.

Test Plan (W=8, N_PP=2):
- Basic product (A=5, B=3): beats 0xFB then 0x14 -> one cycle after the second beat, p_valid=1, p_data=0x0F, ovf=0; with p_ready=1, returns to ACC and pp_ready=1 the next cycle.
- Negative product (A=3, B=-2): beats 0xFA then 0x00 -> p_data=0xFA; hold p_ready=0 for 5 cycles -> p_data stays 0xFA, pp_ready stays 0, beats are not accepted.
- Overflow: beats 0x70, 0x70 -> p_data=0xE0; ovf=1 with BOOTH_ACC_OVF_EN defined, ovf=0 without. The next product 0x01, 0x01 -> p_data=0x02, ovf=0.
- Clear mid-product: beat 0x10 accepted, then clear=1 together with pp_valid=1 and pp_data=0x20 -> pp_ready=0 that cycle, busy=0 next cycle. A following 0x03, 0x04 -> p_data=0x07.
- Async reset in OUT: after beats 0x11, 0x22 (p_valid=1), pulse rst_n=0 between clock edges -> p_valid=0 and pp_ready=1 immediately; a subsequent 0x01, 0x02 -> p_data=0x03.
- Back-to-back with gaps: pp_valid toggling randomly over 4 products, p_ready always 1 -> exactly 4 p_valid pulses, each sum matching the reference model modulo 256.
